sort_ctrl_fsm: RTL and testbench

- Control state machine for the in-place RAM sort datapath.
- Consumes the datapath status flags zi, zj and AgtB.
- Drives the datapath control strobes: Wr, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, and the datapath start/address-mux select (busy).
- Runs a pairwise exchange sort (ascending) over K entries, then signals done to the host.

---
 rtl/sort_ctrl_fsm.sv | 114 +++++++++++
 tb/tb_sort_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_ctrl_fsm.sv
// sort_ctrl_fsm: control FSM for the in-place RAM pairwise exchange sort.
// Sorts ascending over K entries. Optional sort-cycle counter is enabled by
// defining SORT_CYCLE_CNT_EN; otherwise cycles is tied to zero.
module sort_ctrl_fsm #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          zi,
  input  logic          zj,
  input  logic          AgtB,
  output logic          busy,
  output logic          Wr,
  output logic          Li,
  output logic          Ei,
  output logic          Lj,
  output logic          Ej,
  output logic          EA,
  output logic          EB,
  output logic          Csel,
  output logic          Bout,
  output logic          done,
  output logic [CW-1:0] cycles
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPARE,
    S_WR_J,
    S_WR_I,
    S_RELOAD_A,
    S_NEXT_J,
    S_NEXT_I,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Next-state selection from current state and datapath flags.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD_A;
      S_LOAD_A:   state_nxt = S_LOAD_B;
      S_LOAD_B:   state_nxt = S_COMPARE;
      S_COMPARE:  state_nxt = AgtB ? S_WR_J : S_NEXT_J;
      S_WR_J:     state_nxt = S_WR_I;
      S_WR_I:     state_nxt = S_RELOAD_A;
      S_RELOAD_A: state_nxt = S_NEXT_J;
      S_NEXT_J:   state_nxt = zj ? S_NEXT_I : S_LOAD_B;
      S_NEXT_I:   state_nxt = zi ? S_DONE : S_LOAD_A;
      S_DONE:     if (!start) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register; Moore strobes are registered by decoding the next state,
  // so each strobe is valid for exactly the cycle spent in its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      Wr    <= 1'b0;
      Lj    <= 1'b0;
      EA    <= 1'b0;
      EB    <= 1'b0;
      Csel  <= 1'b0;
      Bout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= !(state_nxt inside {S_IDLE, S_DONE});
      Wr    <= state_nxt inside {S_WR_J, S_WR_I};
      Lj    <= (state_nxt == S_LOAD_A);
      EA    <= state_nxt inside {S_LOAD_A, S_RELOAD_A};
      EB    <= (state_nxt == S_LOAD_B);
      Csel  <= state_nxt inside {S_LOAD_B, S_WR_J};
      Bout  <= (state_nxt == S_WR_I);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Flag-qualified strobes: Li is the Mealy start acknowledge; Ei/Ej depend
  // on the live zi/zj flags in NEXT_I/NEXT_J. rst masks Li while asserted.
  always_comb begin
    Li = (state == S_IDLE) && start && !rst;
    Ei = (state == S_NEXT_I) && !zi;
    Ej = (state == S_NEXT_J) && !zj;
  end

`ifdef SORT_CYCLE_CNT_EN
  logic [CW-1:0] cnt_q;

  // Sort-cycle counter: cleared on start acceptance, counts busy cycles
  // with saturation, holds in DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == S_IDLE && start) begin
      cnt_q <= '0;
    end else if (busy && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cycles = cnt_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_sort_ctrl_fsm.sv
// tb_sort_ctrl_fsm: bench for sort_ctrl_fsm with a datapath/RAM model and a
// reference strobe trace derived from the exchange-sort algorithm.
module tb_sort_ctrl_fsm;

  localparam int unsigned CW = 16;
  localparam int K = 16;

  // Strobe vector bit order: {busy,Wr,Li,Ei,Lj,Ej,EA,EB,Csel,Bout,done}
  localparam logic [10:0] B_BUSY = 11'b100_0000_0000;
  localparam logic [10:0] B_WR   = 11'b010_0000_0000;
  localparam logic [10:0] B_EI   = 11'b000_1000_0000;
  localparam logic [10:0] B_LJ   = 11'b000_0100_0000;
  localparam logic [10:0] B_EJ   = 11'b000_0010_0000;
  localparam logic [10:0] B_EA   = 11'b000_0001_0000;
  localparam logic [10:0] B_EB   = 11'b000_0000_1000;
  localparam logic [10:0] B_CSEL = 11'b000_0000_0100;
  localparam logic [10:0] B_BOUT = 11'b000_0000_0010;
  localparam logic [10:0] B_DONE = 11'b000_0000_0001;

  typedef struct packed {
    logic [10:0] bits;
    int unsigned cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic zi, zj, AgtB;
  logic busy, Wr, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, done;
  logic [CW-1:0] cycles;

  sort_ctrl_fsm #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .zi(zi), .zj(zj), .AgtB(AgtB),
    .busy(busy), .Wr(Wr), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej), .EA(EA),
    .EB(EB), .Csel(Csel), .Bout(Bout), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Datapath + RAM model
  logic [7:0] ram [K];
  logic [7:0] init_mem [K];
  logic       do_load = 1'b0;
  logic [3:0] i = '0, j = '0;
  logic [7:0] ra = '0, rb = '0;
  logic [3:0] addr;

  assign addr = Csel ? j : i;
  assign zi   = (i == 4'd14);
  assign zj   = (j == 4'd15);
  assign AgtB = (ra > rb);

  always @(posedge clk) begin
    if (do_load) begin
      for (int k = 0; k < K; k++) ram[k] <= init_mem[k];
    end else if (Wr) begin
      ram[addr] <= Bout ? rb : ra;
    end
    if (EA) ra <= ram[addr];
    if (EB) rb <= ram[addr];
    if (Li) i <= '0; else if (Ei) i <= i + 4'd1;
    if (Lj) j <= i + 4'd1; else if (Ej) j <= j + 4'd1;
  end

  // Scoreboard state
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  int   trace_idx = 0;
  int   done_at = -1;
  int   wr_seen = 0;
  int   exp_busy = 0;
  int   exp_swaps = 0;
  logic [7:0] model_mem [K];

  function automatic logic [10:0] act_bits();
    return {busy, Wr, Li, Ei, Lj, Ej, EA, EB, Csel, Bout, done};
  endfunction

  task automatic push(input logic [10:0] b);
    vec_t v;
    v.bits = b;
    v.cyc  = exp_q.size();
    exp_q.push_back(v);
  endtask

  // Expected per-cycle strobe trace of the exchange sort on d[]
  task automatic build_trace(input logic [7:0] d [K]);
    logic [7:0] m [K];
    logic [7:0] a, t;
    exp_q.delete();
    exp_swaps = 0;
    for (int k = 0; k < K; k++) m[k] = d[k];
    for (int ii = 0; ii <= K - 2; ii++) begin
      push(B_BUSY | B_EA | B_LJ);
      a = m[ii];
      for (int jj = ii + 1; jj <= K - 1; jj++) begin
        push(B_BUSY | B_CSEL | B_EB);
        push(B_BUSY);
        if (a > m[jj]) begin
          push(B_BUSY | B_CSEL | B_WR);
          push(B_BUSY | B_BOUT | B_WR);
          push(B_BUSY | B_EA);
          t = m[jj]; m[jj] = a; m[ii] = t; a = t;
          exp_swaps++;
        end
        push((jj != K - 1) ? (B_BUSY | B_EJ) : B_BUSY);
      end
      push((ii != K - 2) ? (B_BUSY | B_EI) : B_BUSY);
    end
    exp_busy = exp_q.size();
    push(B_DONE);
    for (int k = 0; k < K; k++) model_mem[k] = m[k];
  endtask

  // Per-cycle compare against the reference trace
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t ev;
      ev = exp_q.pop_front();
      n_vec++;
      if (act_bits() !== ev.bits) begin
        n_bad++;
        $display("FAIL strobes[%0d] act=%b exp=%b", trace_idx, act_bits(), ev.bits);
      end
`ifdef SORT_CYCLE_CNT_EN
      n_vec++;
      if (cycles !== CW'(ev.cyc)) begin
        n_bad++;
        $display("FAIL cycles[%0d] act=%0d exp=%0d", trace_idx, cycles, ev.cyc);
      end
`endif
      if (Wr) wr_seen++;
      if (done && done_at < 0) done_at = trace_idx + 1;
      trace_idx++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic load_ram(input logic [7:0] d [K]);
    @(negedge clk);
    for (int k = 0; k < K; k++) init_mem[k] = d[k];
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
  endtask

  // Full sort run with latency, write-count and readback checks
  task automatic run_sort(input string name, input logic [7:0] d [K],
                          input logic [7:0] want [K], input int exp_lat,
                          input int exp_wr, input bit hold);
    bit ok;
    load_ram(d);
    @(negedge clk);
    start = 1'b1;
    #1 check({name, " Li"}, int'(Li), 1);
    @(posedge clk);
    #1;
    trace_idx = 0; done_at = -1; wr_seen = 0;
    build_trace(d);
    if (!hold) start = 1'b0;
    for (int c = 0; c < 2000 && exp_q.size() > 0; c++) @(posedge clk);
    check({name, " drain"}, exp_q.size(), 0);
    check({name, " latency"}, done_at, exp_lat);
    check({name, " wr_pulses"}, wr_seen, exp_wr);
    check({name, " model_swaps"}, 2 * exp_swaps, exp_wr);
    ok = 1'b1;
    for (int k = 0; k < K; k++) if (ram[k] !== want[k] || model_mem[k] !== want[k]) ok = 1'b0;
    check({name, " readback"}, int'(ok), 1);
    if (hold) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check({name, " hold_done"}, int'({busy, done, Li}), 3'b010);
      end
      start = 1'b0;
    end
    @(posedge clk);
    #1 check({name, " idle"}, int'({busy, done}), 0);
`ifdef SORT_CYCLE_CNT_EN
    check({name, " cycles_hold"}, int'(cycles), exp_busy);
`else
    check({name, " cycles_tied"}, int'(cycles), 0);
`endif
  endtask

  logic [7:0] d_sorted [K], d_one [K], d_rev [K], d_eq [K];
  bit got;

  initial begin
    for (int k = 0; k < K; k++) begin
      d_sorted[k] = 8'(k);
      d_one[k]    = 8'(k);
      d_rev[k]    = 8'(K - 1 - k);
      d_eq[k]     = 8'h5A;
    end
    d_one[0] = 8'd1;
    d_one[1] = 8'd0;

    rst = 1'b1;
    #1 check("reset_outputs", int'(act_bits()), 0);
    check("reset_cycles", int'(cycles), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_reset", int'({busy, done, Wr}), 0);

    run_sort("sorted", d_sorted, d_sorted, 391, 0, 1'b0);
    run_sort("one_swap", d_one, d_sorted, 394, 2, 1'b0);
    run_sort("reverse", d_rev, d_sorted, 751, 240, 1'b0);
    run_sort("equal", d_eq, d_eq, 391, 0, 1'b0);

    // Reset in LOAD_B mid-sort
    load_ram(d_rev);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1 if (EB) got = 1'b1;
    end
    check("reach_load_b", int'(got), 1);
    exp_q.delete();
    rst = 1'b1;
    #1 check("midsort_rst_outputs", int'(act_bits()), 0);
    check("midsort_rst_cycles", int'(cycles), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("midsort_rst_idle", int'({busy, done, Li}), 0);

    // Restart after reset, then start held through DONE, then a fresh start
    run_sort("after_rst", d_rev, d_sorted, 751, 240, 1'b0);
    run_sort("held", d_sorted, d_sorted, 391, 0, 1'b1);
    run_sort("restart", d_one, d_sorted, 394, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
